// File: rtl/seq_pkg.sv
// +-----------------------------------------------------------------+
// | seq_pkg: state encoding and length clamp for iter_sequencer     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  // A zero-length pass or run is treated as length one.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_sequencer.sv
// +-----------------------------------------------------------------+
// | iter_sequencer: two-level (inner/outer) iteration sequencer     |
// | with per-pass lookahead flags.  Rev 1.0                         |
// +-----------------------------------------------------------------+
`default_nettype none

module iter_sequencer
  import seq_pkg::*;
#(
  parameter int W        = 10,
  parameter int OW       = 12,
  parameter int MAX_LEAD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                restart,
  input  logic [W-1:0]        inner_len,
  input  logic [OW-1:0]       outer_len,
  output logic                active,
  output logic [W-1:0]        cnt,
  output logic [OW-1:0]       round,
  output logic [MAX_LEAD:0]   lead,
  output logic                all_done
);

  seq_state_t      state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]   round_q, round_d;
  logic [W-1:0]    il_q, il_d;
  logic [OW-1:0]   ol_q, ol_d;
  logic [W-1:0]    w_rem;
  logic            w_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      il_q    <= W'(1);
      ol_q    <= OW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      il_q    <= il_d;
      ol_q    <= ol_d;
    end
  end

  // restart is honoured from every state, so the load path is shared.
  assign w_load = ce && restart;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    il_d    = il_q;
    ol_d    = ol_q;
    if (w_load) begin
      state_d = S_RUN;
      cnt_d   = '0;
      round_d = '0;
      il_d    = W'(clamp_len(32'(inner_len)));
      ol_d    = OW'(clamp_len(32'(outer_len)));
    end else if (ce) begin
      case (state_q)
        S_RUN: begin
          if (cnt_q < il_q - W'(1)) begin
            cnt_d = cnt_q + W'(1);
          end else begin
            cnt_d = '0;
            if (round_q < ol_q - OW'(1)) begin
              round_d = round_q + OW'(1);
            end else begin
              round_d = '0;
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign active   = (state_q == S_RUN);
  assign all_done = (state_q == S_DONE);
  assign cnt      = cnt_q;
  assign round    = round_q;
  assign w_rem    = il_q - W'(1) - cnt_q;

  generate
    for (genvar d = 0; d <= MAX_LEAD; d++) begin : g_lead
      if (d < (1 << W)) begin : g_cmp
        assign lead[d] = active && (w_rem == W'(d));
      end else begin : g_zero
        assign lead[d] = 1'b0;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_iter_sequencer.sv
// +-----------------------------------------------------------------+
// | tb_iter_sequencer: directed + random bench with a trace model   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_iter_sequencer;

  localparam int W        = 10;
  localparam int OW       = 12;
  localparam int MAX_LEAD = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ce = 1'b0;
  logic              restart = 1'b0;
  logic [W-1:0]      inner_len = '0;
  logic [OW-1:0]     outer_len = '0;
  logic              active;
  logic [W-1:0]      cnt;
  logic [OW-1:0]     round;
  logic [MAX_LEAD:0] lead;
  logic              all_done;

  int n_pass  = 0;
  int n_total = 0;

  iter_sequencer #(.W(W), .OW(OW), .MAX_LEAD(MAX_LEAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .restart   (restart),
    .inner_len (inner_len),
    .outer_len (outer_len),
    .active    (active),
    .cnt       (cnt),
    .round     (round),
    .lead      (lead),
    .all_done  (all_done)
  );

  always #5 clk = ~clk;

  // Model: an accepted restart expands the whole run into a list of
  // (round, cnt) cycles followed by one done cycle; each ce edge consumes one.
  typedef struct {
    bit done;
    int r;
    int c;
    int il;
  } item_t;

  item_t trace[$];

  task automatic load_run(input int il_in, input int ol_in);
    int il;
    int ol;
    item_t it;
    il = (il_in == 0) ? 1 : il_in;
    ol = (ol_in == 0) ? 1 : ol_in;
    trace.delete();
    for (int r = 0; r < ol; r++) begin
      for (int c = 0; c < il; c++) begin
        it.done = 1'b0; it.r = r; it.c = c; it.il = il;
        trace.push_back(it);
      end
    end
    it.done = 1'b1; it.r = 0; it.c = 0; it.il = il;
    trace.push_back(it);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    bit              e_act;
    bit              e_done;
    logic [MAX_LEAD:0] e_lead;
    int              rem;
    e_act  = 1'b0;
    e_done = 1'b0;
    e_lead = '0;
    if (trace.size() > 0) begin
      if (trace[0].done) begin
        e_done = 1'b1;
      end else begin
        e_act = 1'b1;
        rem = trace[0].il - 1 - trace[0].c;
        if (rem <= MAX_LEAD) e_lead[rem] = 1'b1;
      end
    end
    chk("active", 32'(active), 32'(e_act));
    chk("all_done", 32'(all_done), 32'(e_done));
    chk("lead", 32'(lead), 32'(e_lead));
    if (e_act) begin
      chk("cnt", 32'(cnt), 32'(trace[0].c));
      chk("round", 32'(round), 32'(trace[0].r));
    end
  endtask

  // One clock: model follows the inputs seen at the edge, then outputs are checked.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      trace.delete();
    end else if (ce) begin
      if (restart) load_run(int'(inner_len), int'(outer_len));
      else if (trace.size() > 0) void'(trace.pop_front());
    end
    #1;
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start(input int il, input int ol);
    inner_len = W'(il);
    outer_len = OW'(ol);
    restart   = 1'b1;
    ce        = 1'b1;
    step();
    restart   = 1'b0;
  endtask

  initial begin
    // Reset values
    rst = 1'b1; ce = 1'b0;
    cycles(2);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_round", 32'(round), 32'd0);
    rst = 1'b0; ce = 1'b1;
    cycles(1);

    // Single pass of 9
    start(9, 1);
    cycles(12);

    // 4 x 3 with a mid-run change on the length inputs
    start(4, 3);
    inner_len = W'(7); outer_len = OW'(5);
    cycles(15);

    // Stall two cycles at cnt=4
    start(9, 1);
    cycles(4);
    chk("stall_cnt", 32'(cnt), 32'd4);
    ce = 1'b0;
    cycles(2);
    chk("stall_hold", 32'(cnt), 32'd4);
    ce = 1'b1;
    cycles(8);

    // Abort at cnt=6, round=1 with a 5-cycle pass
    start(9, 2);
    cycles(15);
    chk("abort_cnt", 32'(cnt), 32'd6);
    chk("abort_round", 32'(round), 32'd1);
    start(5, 1);
    chk("restart_cnt", 32'(cnt), 32'd0);
    cycles(7);

    // Zero lengths clamp to one
    start(0, 2);
    cycles(4);

    // Back-to-back: restart while in DONE
    start(2, 1);
    cycles(2);
    chk("done_seen", 32'(all_done), 32'd1);
    start(3, 1);
    cycles(5);

    // Reset with ce low at cnt=3, then a clean restart
    start(9, 1);
    cycles(3);
    ce = 1'b0; rst = 1'b1;
    step();
    chk("rst2_cnt", 32'(cnt), 32'd0);
    chk("rst2_round", 32'(round), 32'd0);
    rst = 1'b0;
    start(4, 2);
    cycles(10);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ce        = ($urandom_range(0, 9) < 8);
      restart   = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      inner_len = W'($urandom_range(0, 12));
      outer_len = OW'($urandom_range(0, 4));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_sequencer.md
# iter_sequencer

Two-level iteration sequencer for the RSA datapath. An inner counter runs one pass of `inner_len` cycles, for example one Montgomery multiplication over the operand digits. An outer counter repeats that pass `outer_len` times, for example the steps of one exponentiation. A vector of lookahead flags tells downstream pipeline stages how many cycles remain in the current pass, replacing the fixed `ready_next`/`ready_next_prev`/`ready_next_3prev` taps of the single-level counter.

## Interface
Parameters:
- `W`, default 10: inner count width; `inner_len` legal range 1..2^W-1.
- `OW`, default 12: outer count width; `outer_len` legal range 1..2^OW-1.
- `MAX_LEAD`, default 3: highest lookahead distance; `lead` is `MAX_LEAD+1` bits wide.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset; overrides `ce` and `restart`.
- `ce`  in  1  clock enable; gates every state update except `rst`.
- `restart`  in  1  start or re-start a run; sampled only when `ce`=1.
- `inner_len`  in  W  pass length in cycles; latched on accepted `restart`.
- `outer_len`  in  OW  number of passes; latched on accepted `restart`.
- `active`  out  1  high in RUN state.
- `cnt`  out  W  inner index, 0..`inner_len`-1.
- `round`  out  OW  outer index, 0..`outer_len`-1.
- `lead`  out  MAX_LEAD+1  `lead[d]`=1 when exactly d cycles remain after the current one in this pass.
- `all_done`  out  1  high in DONE state.

## Operation
- States: IDLE, RUN, DONE.
- Length latch: `inner_len`=0 latches as 1; `outer_len`=0 latches as 1.
- The latched copies (`il_q`, `ol_q`) are the only values used during a run. Changes on the length inputs mid-run have no effect.
- IDLE -> RUN on `ce`&&`restart`: `cnt`=0, `round`=0, lengths latched.
- RUN, `ce`=1, no restart:
  - If `cnt` < `il_q`-1: `cnt`++.
  - Else `cnt`=0. If `round` < `ol_q`-1: `round`++. Else -> DONE.
- RUN, `ce`=1, `restart`=1: abort, reload lengths, `cnt`=0, `round`=0, stay in RUN. No `all_done` is produced for the aborted run.
- DONE -> IDLE on the next `ce`=1 edge. If `restart` is also high, go to RUN instead (back-to-back runs).
- `ce`=0: state, `cnt`, `round` and latched lengths hold. Outputs are decoded from state, so they also hold.
- `lead[d]` = `active` && (`il_q`-1-`cnt` == d). `lead[0]` marks the last cycle of every pass.
- A flag `lead[d]` with d ≥ `il_q` never asserts. Flags never look across pass boundaries.
- Arithmetic: the remaining-cycles difference is computed at W bits and compared against constants 0..MAX_LEAD. No wrap is possible within the legal range.

## Timing
- Reset values: state IDLE, `active`=0, `cnt`=0, `round`=0, `lead`=0, `all_done`=0, latched lengths 1.
- Accepted `restart` at edge N: `active`=1 and `cnt`=0 during cycle N+1.
- With `ce` held at 1, `active` stays high for exactly `il_q`×`ol_q` cycles.
- `all_done` asserts in the cycle right after the last RUN cycle. It lasts exactly one cycle if `ce`=1, longer if `ce` is low.
- All outputs are Moore-decoded from registers, with zero combinational paths from the inputs. `lead` is valid in the same cycle as `cnt`.
- `rst` mid-run, with any `ce` value: the next cycle shows the reset values.

## Structure
- Package `seq_pkg`: state enum `seq_state_t` (IDLE, RUN, DONE) and the length-clamp function.
- `lead` decode is a small generate loop inside the block. No sub-module is needed.
- The module itself is one register process plus output decode.

## Test plan
- `rst`, then `restart` with `inner_len`=9, `outer_len`=1:
  - `active` high for 9 cycles.
  - `lead[3]` at `cnt`=5, `lead[1]` at `cnt`=7, `lead[0]` at `cnt`=8.
  - `all_done` one cycle later, then IDLE.
- `inner_len`=4, `outer_len`=3:
  - `cnt` runs 0..3 three times and `round` runs 0,1,2.
  - `lead[0]` pulses 3 times, `active` lasts 12 cycles, single `all_done`.
- `inner_len`=9 run with `ce`=0 for 2 cycles at `cnt`=4:
  - `cnt`, `round` and `lead` frozen during the stall.
  - `active` span becomes 11 cycles and `all_done` is still one pulse.
- `restart` with `inner_len`=5 while running at `cnt`=6, `round`=1:
  - Next cycle `cnt`=0, `round`=0.
  - New 5-cycle pass; no `all_done` for the aborted run.
- `inner_len`=0, `outer_len`=2, `MAX_LEAD`=3:
  - Clamped to 1, so `active` lasts 2 cycles with `lead[0]` high both cycles.
  - `lead[3:1]` never assert.
- `rst`=1 with `ce`=0 at `cnt`=3: next cycle IDLE with all outputs at their reset values. A subsequent `restart` starts cleanly.
